// File: rtl/tpu_cmd_pkg.sv
// tpu_cmd_pkg: command word layout, packed command type and issuer state
// encoding, shared by tpu_cmd_issuer and the control_unit decode path.
package tpu_cmd_pkg;

    localparam int CMD_WIDTH  = 64;
    localparam int CMD_DIM_W  = 8;
    localparam int CMD_ADDR_W = 10;

    localparam int CMD_M_LSB = 0;
    localparam int CMD_K_LSB = 8;
    localparam int CMD_N_LSB = 16;
    localparam int CMD_A_LSB = 24;
    localparam int CMD_B_LSB = 34;
    localparam int CMD_C_LSB = 44;
    localparam int CMD_D_LSB = 54;

    // True when the offsets above tile the command word contiguously.
    localparam bit CMD_LAYOUT_OK =
        (CMD_K_LSB == CMD_M_LSB + CMD_DIM_W) &&
        (CMD_N_LSB == CMD_K_LSB + CMD_DIM_W) &&
        (CMD_A_LSB == CMD_N_LSB + CMD_DIM_W) &&
        (CMD_B_LSB == CMD_A_LSB + CMD_ADDR_W) &&
        (CMD_C_LSB == CMD_B_LSB + CMD_ADDR_W) &&
        (CMD_D_LSB == CMD_C_LSB + CMD_ADDR_W) &&
        (CMD_D_LSB + CMD_ADDR_W == CMD_WIDTH);

    // Packed tile command; first member lands in the MSBs.
    typedef struct packed {
        logic [CMD_ADDR_W-1:0] d;
        logic [CMD_ADDR_W-1:0] c;
        logic [CMD_ADDR_W-1:0] b;
        logic [CMD_ADDR_W-1:0] a;
        logic [CMD_DIM_W-1:0]  n;
        logic [CMD_DIM_W-1:0]  k;
        logic [CMD_DIM_W-1:0]  m;
    } tpu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } issuer_state_t;

    // A tile dimension is legal when it is non-zero and fits the array.
    function automatic logic dim_legal(input logic [CMD_DIM_W-1:0] dim,
                                       input logic [CMD_DIM_W-1:0] max_dim);
        return (dim != '0) && (dim <= max_dim);
    endfunction

endpackage

// File: rtl/tpu_credit_counter.sv
// tpu_credit_counter: up/down count of issued-but-not-retired tiles.
// Saturates at MAX_OUTSTANDING and floors at zero; a retire seen at zero
// raises the sticky spurious_done flag, which clears only on reset.
module tpu_credit_counter #(
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          spurious_done
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // Next count: simultaneous issue and retire cancel out.
    always_comb begin
        // NOTE: default assignment first so every path drives count_next and no latch is inferred.
        count_next = count;
        if (inc && !dec) begin
            if (count != MAX_CNT) count_next = count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0) count_next = count - 1'b1;
        end
    end

    // Count register and sticky spurious-retire flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            spurious_done <= 1'b0;
        end else begin
            count <= count_next;
            if (dec && (count == '0)) spurious_done <= 1'b1;
        end
    end

endmodule

// File: rtl/tpu_cmd_issuer.sv
// tpu_cmd_issuer: accepts one GEMM job descriptor and expands it into a
// stream of packed 64-bit tile commands, throttled by retire credits.
// Optional build macro CMD_ISSUER_PERF_EN adds three performance counters.
module tpu_cmd_issuer
    import tpu_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int MAX_OUTSTANDING      = 4,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [7:0]            job_tiles,
    input  logic [7:0]            job_m,
    input  logic [7:0]            job_k,
    input  logic [7:0]            job_n,
    input  logic [ADDR_WIDTH-1:0] job_a_base,
    input  logic [ADDR_WIDTH-1:0] job_b_base,
    input  logic [ADDR_WIDTH-1:0] job_c_base,
    input  logic [ADDR_WIDTH-1:0] job_d_base,
    input  logic [ADDR_WIDTH-1:0] job_a_stride,
    input  logic [ADDR_WIDTH-1:0] job_b_stride,
    input  logic [ADDR_WIDTH-1:0] job_c_stride,
    input  logic [ADDR_WIDTH-1:0] job_d_stride,
    input  logic                  job_abort,
    output logic                  cmd_valid,
    output logic [63:0]           cmd_data,
    input  logic                  cmd_ready,
    input  logic                  done_irq,
    output logic                  job_done,
    output logic                  job_aborted,
    output logic                  job_err,
    output logic [OW-1:0]         outstanding,
    output logic                  spurious_done
`ifdef CMD_ISSUER_PERF_EN
   ,output logic [31:0]           perf_job_cycles,
    output logic [31:0]           perf_stall_ready,
    output logic [31:0]           perf_stall_credit
`endif
);

    // Address fields in the command word are fixed at 10 bits.
    generate
        if (ADDR_WIDTH != CMD_ADDR_W || !CMD_LAYOUT_OK || $bits(tpu_cmd_t) != CMD_WIDTH) begin : g_bad_layout
            $error("tpu_cmd_issuer: ADDR_WIDTH must be 10 to match the command word layout");
        end
        if (MAX_OUTSTANDING < 1) begin : g_bad_credit
            $error("tpu_cmd_issuer: MAX_OUTSTANDING must be at least 1");
        end
    endgenerate

    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);
    localparam logic [7:0]    MAX_DIM = 8'(SYSTOLIC_ARRAY_WIDTH);

    issuer_state_t         state;
    logic [7:0]            remaining;
    logic [7:0]            dim_m, dim_k, dim_n;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr, c_addr, d_addr;
    logic [ADDR_WIDTH-1:0] a_stride, b_stride, c_stride, d_stride;
    logic                  aborted;
    logic                  handshake;
    logic                  abort_now;
    logic                  job_legal;
    logic                  accept;
    logic [OW-1:0]         credit_next;
    tpu_cmd_t              cmd_word;

    assign handshake   = cmd_valid && cmd_ready;
    assign abort_now   = aborted || job_abort;
    assign job_legal   = (job_tiles != 8'd0) && dim_legal(job_m, MAX_DIM) &&
                         dim_legal(job_k, MAX_DIM) && dim_legal(job_n, MAX_DIM);
    assign accept      = (state == ST_IDLE) && job_valid && job_legal;
    assign job_aborted = aborted;

    tpu_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk           (clk),
        .rst           (rst),
        .inc           (handshake),
        .dec           (done_irq),
        .count         (outstanding),
        .count_next    (credit_next),
        .spurious_done (spurious_done)
    );

    // The command word is always the current tile's fields.
    assign cmd_word = '{d: d_addr, c: c_addr, b: b_addr, a: a_addr,
                        n: dim_n, k: dim_k, m: dim_m};
    assign cmd_data = cmd_word;

    // Strides are only read after a job has been accepted, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_stride <= job_a_stride;
            b_stride <= job_b_stride;
            c_stride <= job_c_stride;
            d_stride <= job_d_stride;
        end
    end

    // Issuer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            job_ready <= 1'b1;
            cmd_valid <= 1'b0;
            job_done  <= 1'b0;
            job_err   <= 1'b0;
            aborted   <= 1'b0;
            remaining <= '0;
            // NOTE: address and dimension registers are reset because they drive cmd_data directly.
            dim_m     <= '0;
            dim_k     <= '0;
            dim_n     <= '0;
            a_addr    <= '0;
            b_addr    <= '0;
            c_addr    <= '0;
            d_addr    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every branch reads the pre-edge state.
            job_done <= 1'b0;
            job_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (job_valid && !job_legal) begin
                        job_err <= 1'b1;
                    end else if (accept) begin
                        state     <= ST_ISSUE;
                        job_ready <= 1'b0;
                        aborted   <= 1'b0;
                        remaining <= job_tiles;
                        dim_m     <= job_m;
                        dim_k     <= job_k;
                        dim_n     <= job_n;
                        a_addr    <= job_a_base;
                        b_addr    <= job_b_base;
                        c_addr    <= job_c_base;
                        d_addr    <= job_d_base;
                        cmd_valid <= (credit_next < MAX_CNT);
                    end
                end
                ST_ISSUE: begin
                    if (job_abort) aborted <= 1'b1;
                    if (handshake) begin
                        remaining <= remaining - 8'd1;
                        a_addr    <= a_addr + a_stride;
                        b_addr    <= b_addr + b_stride;
                        c_addr    <= c_addr + c_stride;
                        d_addr    <= d_addr + d_stride;
                    end
                    if (handshake && (remaining == 8'd1)) begin
                        state     <= ST_DRAIN;
                        cmd_valid <= 1'b0;
                    end else if (cmd_valid && !cmd_ready) begin
                        // A presented word is held until it is taken, even under abort.
                        cmd_valid <= 1'b1;
                    end else if (abort_now) begin
                        state     <= ST_DRAIN;
                        cmd_valid <= 1'b0;
                    end else begin
                        cmd_valid <= (credit_next < MAX_CNT);
                    end
                end
                ST_DRAIN: begin
                    if (job_abort) aborted <= 1'b1;
                    if (outstanding == '0) begin
                        state     <= ST_IDLE;
                        job_done  <= 1'b1;
                        job_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    job_ready <= 1'b1;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMD_ISSUER_PERF_EN
    // Performance counters: cleared on acceptance, frozen while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_job_cycles   <= '0;
            perf_stall_ready  <= '0;
            perf_stall_credit <= '0;
        end else if (accept) begin
            perf_job_cycles   <= '0;
            perf_stall_ready  <= '0;
            perf_stall_credit <= '0;
        end else if (state != ST_IDLE) begin
            perf_job_cycles <= perf_job_cycles + 32'd1;
            if (cmd_valid && !cmd_ready) perf_stall_ready <= perf_stall_ready + 32'd1;
            if ((state == ST_ISSUE) && !aborted && (outstanding == MAX_CNT))
                perf_stall_credit <= perf_stall_credit + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tpu_cmd_issuer.sv
// tb_tpu_cmd_issuer: directed tests for tpu_cmd_issuer with a queue-based
// reference model checked every cycle on the falling clock edge.
module tb_tpu_cmd_issuer;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid, job_ready, job_abort;
    logic [7:0]  job_tiles, job_m, job_k, job_n;
    logic [9:0]  job_a_base, job_b_base, job_c_base, job_d_base;
    logic [9:0]  job_a_stride, job_b_stride, job_c_stride, job_d_stride;
    logic        cmd_valid, cmd_ready, done_irq;
    logic [63:0] cmd_data;
    logic        job_done, job_aborted, job_err, spurious_done;
    logic [2:0]  outstanding;

    tpu_cmd_issuer #(
        .ADDR_WIDTH           (10),
        .SYSTOLIC_ARRAY_WIDTH (16),
        .MAX_OUTSTANDING      (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_tiles     (job_tiles),
        .job_m         (job_m),
        .job_k         (job_k),
        .job_n         (job_n),
        .job_a_base    (job_a_base),
        .job_b_base    (job_b_base),
        .job_c_base    (job_c_base),
        .job_d_base    (job_d_base),
        .job_a_stride  (job_a_stride),
        .job_b_stride  (job_b_stride),
        .job_c_stride  (job_c_stride),
        .job_d_stride  (job_d_stride),
        .job_abort     (job_abort),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .done_irq      (done_irq),
        .job_done      (job_done),
        .job_aborted   (job_aborted),
        .job_err       (job_err),
        .outstanding   (outstanding),
        .spurious_done (spurious_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] exp_q[$];     // commands the job should still present, in order
    logic [9:0]  hs_a[$];      // A address of each accepted command
    int          hs_cyc[$];    // cycle number of each accepted command
    int          mdl_out;
    bit          mdl_spur;
    bit          prev_stall;
    bit          mon_hs;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            mdl_out    = 0;
            mdl_spur   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("outstanding", outstanding, mdl_out);
            check("spurious_done", spurious_done, mdl_spur);
            if (prev_stall) check("cmd_valid_held", cmd_valid, 1);
            if (cmd_valid) begin
                check("credit_respected", mdl_out < MAX_OUT, 1);
                if (exp_q.size() == 0) check("cmd_unexpected", cmd_valid, 0);
                else                   check("cmd_data", cmd_data, exp_q[0]);
            end
            mon_hs = cmd_valid && cmd_ready;
            if (mon_hs) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                hs_a.push_back(cmd_data[33:24]);
                hs_cyc.push_back(cyc);
            end
            if (mon_hs && !done_irq)      mdl_out++;
            else if (done_irq && mdl_out == 0) mdl_spur = 1'b1;
            else if (done_irq && !mon_hs) mdl_out--;
            prev_stall = cmd_valid && !cmd_ready;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [7:0] tiles, input logic [7:0] m, input logic [7:0] k,
                          input logic [7:0] n, input logic [9:0] ab, input logic [9:0] bb,
                          input logic [9:0] cb, input logic [9:0] db, input logic [9:0] as_,
                          input logic [9:0] bs, input logic [9:0] cs, input logic [9:0] ds);
        int guard = 0;
        bit legal;
        while (!job_ready && guard < 50) begin
            step();
            guard++;
        end
        check("job_ready_before_submit", job_ready, 1);
        exp_q.delete();
        hs_a.delete();
        hs_cyc.delete();
        legal = (tiles != 0) && (m >= 1) && (m <= 16) && (k >= 1) && (k <= 16) &&
                (n >= 1) && (n <= 16);
        if (legal) begin
            for (int i = 0; i < int'(tiles); i++)
                exp_q.push_back({10'(int'(db) + i * int'(ds)), 10'(int'(cb) + i * int'(cs)),
                                 10'(int'(bb) + i * int'(bs)), 10'(int'(ab) + i * int'(as_)),
                                 n, k, m});
        end
        job_tiles = tiles; job_m = m; job_k = k; job_n = n;
        job_a_base = ab; job_b_base = bb; job_c_base = cb; job_d_base = db;
        job_a_stride = as_; job_b_stride = bs; job_c_stride = cs; job_d_stride = ds;
        job_valid = 1'b1;
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic exp_abort);
        int i = 0;
        while (!job_done && i < 100) begin
            step();
            i++;
        end
        check({name, "_job_done"}, job_done, 1);
        check({name, "_job_aborted"}, job_aborted, exp_abort);
        check({name, "_job_ready"}, job_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- directed tests ----------------
    logic [63:0] lit;

    initial begin
        rst = 1'b1; job_valid = 1'b0; job_abort = 1'b0; cmd_ready = 1'b0; done_irq = 1'b0;
        job_tiles = '0; job_m = '0; job_k = '0; job_n = '0;
        job_a_base = '0; job_b_base = '0; job_c_base = '0; job_d_base = '0;
        job_a_stride = '0; job_b_stride = '0; job_c_stride = '0; job_d_stride = '0;
        repeat (3) step();
        check("rst_job_ready", job_ready, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_job_done", job_done, 0);
        check("rst_job_aborted", job_aborted, 0);
        check("rst_job_err", job_err, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_spurious", spurious_done, 0);
        rst = 1'b0;
        step();

        // Single tile, full-size dimensions.
        cmd_ready = 1'b1;
        submit(8'd1, 8'd16, 8'd16, 8'd16, 10'd0, 10'd100, 10'd200, 10'd300, 10'd0, 10'd0, 10'd0, 10'd0);
        lit = {10'd300, 10'd200, 10'd100, 10'd0, 8'd16, 8'd16, 8'd16};
        check("t1_first_valid", cmd_valid, 1);
        check("t1_cmd_data", cmd_data, lit);
        check("t1_job_ready_low", job_ready, 0);
        step();
        check("t1_outstanding", outstanding, 1);
        check("t1_valid_after", cmd_valid, 0);
        done_irq = 1'b1; step(); done_irq = 1'b0;
        check("t1_no_early_done", job_done, 0);
        wait_done("t1", 1'b0);
        step();
        check("t1_done_pulse", job_done, 0);

        // Strided stream with completions overlapping issue.
        submit(8'd3, 8'd8, 8'd8, 8'd8, 10'd0, 10'd0, 10'd0, 10'd0, 10'd16, 10'd16, 10'd16, 10'd16);
        step();
        done_irq = 1'b1; repeat (3) step(); done_irq = 1'b0;
        wait_done("t2", 1'b0);
        check("t2_count", hs_a.size(), 3);
        check("t2_a0", hs_a[0], 0);
        check("t2_a1", hs_a[1], 16);
        check("t2_a2", hs_a[2], 32);
        check("t2_consec01", hs_cyc[1] - hs_cyc[0], 1);
        check("t2_consec12", hs_cyc[2] - hs_cyc[1], 1);

        // Credit limit.
        submit(8'd6, 8'd8, 8'd8, 8'd8, 10'd0, 10'd0, 10'd0, 10'd0, 10'd1, 10'd1, 10'd1, 10'd1);
        repeat (8) step();
        check("t3_hs_at_limit", hs_a.size(), 4);
        check("t3_valid_blocked", cmd_valid, 0);
        check("t3_outstanding", outstanding, 4);
        done_irq = 1'b1; step(); done_irq = 1'b0;
        check("t3_released_valid", cmd_valid, 1);
        check("t3_hs_before_5th", hs_a.size(), 4);
        step();
        check("t3_hs_5th", hs_a.size(), 5);
        check("t3_blocked_again", cmd_valid, 0);
        done_irq = 1'b1; repeat (5) step(); done_irq = 1'b0;
        wait_done("t3", 1'b0);
        check("t3_hs_total", hs_a.size(), 6);

        // Backpressure mid-job.
        submit(8'd4, 8'd4, 8'd8, 8'd2, 10'd10, 10'd20, 10'd30, 10'd40, 10'd1, 10'd1, 10'd1, 10'd1);
        step();
        cmd_ready = 1'b0;
        lit = {10'd41, 10'd31, 10'd21, 10'd11, 8'd2, 8'd8, 8'd4};
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_valid_held", cmd_valid, 1);
            check("t4_data_stable", cmd_data, lit);
        end
        cmd_ready = 1'b1;
        repeat (3) step();
        check("t4_hs_total", hs_a.size(), 4);
        done_irq = 1'b1; repeat (4) step(); done_irq = 1'b0;
        wait_done("t4", 1'b0);

        // Illegal descriptors.
        submit(8'd1, 8'd8, 8'd17, 8'd8, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        check("t5_k17_err", job_err, 1);
        check("t5_k17_ready", job_ready, 1);
        check("t5_k17_no_cmd", cmd_valid, 0);
        step();
        check("t5_err_pulse", job_err, 0);
        repeat (3) step();
        check("t5_k17_no_hs", hs_a.size(), 0);
        submit(8'd0, 8'd4, 8'd4, 8'd4, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        check("t5_zero_tiles_err", job_err, 1);

        // Address wrap past 1023.
        submit(8'd2, 8'd1, 8'd1, 8'd1, 10'd1020, 10'd0, 10'd0, 10'd0, 10'd8, 10'd0, 10'd0, 10'd0);
        repeat (2) step();
        check("t5_wrap_count", hs_a.size(), 2);
        check("t5_wrap_a0", hs_a[0], 1020);
        check("t5_wrap_a1", hs_a[1], 4);
        done_irq = 1'b1; repeat (2) step(); done_irq = 1'b0;
        wait_done("t5", 1'b0);

        // Abort after two tiles, then a spurious completion.
        submit(8'd8, 8'd2, 8'd2, 8'd2, 10'd0, 10'd0, 10'd0, 10'd0, 10'd4, 10'd4, 10'd4, 10'd4);
        step();
        job_abort = 1'b1; step(); job_abort = 1'b0;
        check("t6_valid_off", cmd_valid, 0);
        check("t6_outstanding", outstanding, 2);
        check("t6_aborted_flag", job_aborted, 1);
        repeat (4) step();
        check("t6_no_more_cmds", hs_a.size(), 2);
        check("t6_no_done_yet", job_done, 0);
        done_irq = 1'b1; repeat (2) step(); done_irq = 1'b0;
        wait_done("t6", 1'b1);
        done_irq = 1'b1; step(); done_irq = 1'b0;
        step();
        check("t6_spurious", spurious_done, 1);

        // Abort while a word is held by backpressure.
        cmd_ready = 1'b0;
        submit(8'd5, 8'd3, 8'd3, 8'd3, 10'd0, 10'd0, 10'd0, 10'd0, 10'd2, 10'd2, 10'd2, 10'd2);
        job_abort = 1'b1; step(); job_abort = 1'b0;
        check("t7_held_valid", cmd_valid, 1);
        check("t7_held_data", cmd_data, 64'h0000_0000_0003_0303);
        step();
        check("t7_still_held", cmd_valid, 1);
        cmd_ready = 1'b1;
        step();
        check("t7_one_hs", hs_a.size(), 1);
        check("t7_valid_off", cmd_valid, 0);
        repeat (3) step();
        check("t7_no_more_cmds", hs_a.size(), 1);
        done_irq = 1'b1; step(); done_irq = 1'b0;
        wait_done("t7", 1'b1);

        // A clean job after aborts clears job_aborted.
        submit(8'd1, 8'd5, 8'd6, 8'd7, 10'd1, 10'd2, 10'd3, 10'd4, 10'd0, 10'd0, 10'd0, 10'd0);
        step();
        done_irq = 1'b1; step(); done_irq = 1'b0;
        wait_done("t8", 1'b0);
        check("t8_spurious_sticky", spurious_done, 1);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
